// File: rtl/range_averager.sv
// Moving average of ultrasonic echo widths over a DEPTH-sample window with a
// ready/valid output. Define RANGE_AVERAGER_OUTLIER_REJECT_EN to enable outlier rejection.
module range_averager #(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 4,
  parameter int MAX_JUMP = 444
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_width,
  input  logic             in_timeout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_avg,
  output logic [7:0]       miss_count,
  output logic             overrun
);

  localparam int LOG    = $clog2(DEPTH);
  localparam int SUM_W  = WIDTH + LOG;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  buffer [DEPTH];
  logic [LOG-1:0]    ptr;
  logic [FILL_W-1:0] fill;
  logic [SUM_W-1:0]  sum;
  logic              stage_valid;
  logic              full;
  logic [WIDTH-1:0]  evicted;
  logic [WIDTH-1:0]  avg_now;
  logic              reject;
  logic              take;
  logic              discard;

  // Entries beyond the fill count were never written, so they count as zero.
  assign full    = (fill == FULL);
  assign evicted = full ? buffer[ptr] : '0;
  assign avg_now = sum[SUM_W-1:LOG];

`ifdef RANGE_AVERAGER_OUTLIER_REJECT_EN
  localparam logic [WIDTH-1:0] JUMP = WIDTH'(MAX_JUMP);
  logic [1:0]       reject_run;
  logic [WIDTH-1:0] dist;

  always_comb begin
    dist   = (in_width >= avg_now) ? (in_width - avg_now) : (avg_now - in_width);
    reject = full && (dist > JUMP) && (reject_run != 2'd3);
  end

  // A fourth consecutive outlier is taken as a genuine change of range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject_run <= 2'd0;
    end else if (take) begin
      reject_run <= 2'd0;
    end else if (in_valid && !in_timeout && reject) begin
      reject_run <= reject_run + 2'd1;
    end
  end
`else
  logic [31:0] unused_max_jump;
  assign unused_max_jump = MAX_JUMP;
  assign reject          = 1'b0;
`endif

  assign take    = in_valid && !in_timeout && !reject;
  assign discard = in_valid && (in_timeout || reject);

  always_ff @(posedge clk) begin
    if (take) begin
      buffer[ptr] <= in_width;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum         <= '0;
      ptr         <= '0;
      fill        <= '0;
      stage_valid <= 1'b0;
      miss_count  <= 8'd0;
    end else begin
      stage_valid <= take && (fill >= FULL - FILL_W'(1));
      if (take) begin
        sum <= sum - SUM_W'(evicted) + SUM_W'(in_width);
        ptr <= (ptr == LOG'(DEPTH - 1)) ? '0 : ptr + LOG'(1);
        if (!full) begin
          fill <= fill + FILL_W'(1);
        end
      end
      if (discard && (miss_count != 8'hFF)) begin
        miss_count <= miss_count + 8'd1;
      end
    end
  end

  // Output register: a fresh result always wins over a pending handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_avg   <= '0;
      overrun   <= 1'b0;
    end else if (stage_valid) begin
      out_valid <= 1'b1;
      out_avg   <= avg_now;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_range_averager.sv
// Directed self-checking bench for range_averager (default build, DEPTH=4, WIDTH=12).
module tb_range_averager;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [11:0] in_width;
  logic        in_timeout;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_avg;
  logic [7:0]  miss_count;
  logic        overrun;

  int n_compared   = 0;
  int n_mismatched = 0;

  range_averager #(.WIDTH(12), .DEPTH(4), .MAX_JUMP(444)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_width   (in_width),
    .in_timeout (in_timeout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_avg    (out_avg),
    .miss_count (miss_count),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one sample for exactly one cycle; called at a negedge, returns at the next one.
  task automatic applyStimulus(input logic [11:0] w, input logic to);
    in_valid   = 1'b1;
    in_width   = w;
    in_timeout = to;
    @(negedge clk);
    in_valid   = 1'b0;
    in_timeout = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
      else begin
        n_mismatched++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_width   = '0;
    in_timeout = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 0);
    checkOutput("reset_avg", 32'(out_avg), 0);
    checkOutput("reset_miss", 32'(miss_count), 0);
    checkOutput("reset_overrun", 32'(overrun), 0);
    reset = 1'b0;

    // Priming: no result until four samples have been taken
    applyStimulus(12'd100, 1'b0);
    checkOutput("prime1_valid", 32'(out_valid), 0);
    applyStimulus(12'd200, 1'b0);
    applyStimulus(12'd300, 1'b0);
    idleCycle();
    checkOutput("prime3_valid", 32'(out_valid), 0);
    applyStimulus(12'd400, 1'b0);
    checkOutput("prime4_latency", 32'(out_valid), 0);
    idleCycle();
    checkOutput("prime4_valid", 32'(out_valid), 1);
    checkOutput("prime4_avg", 32'(out_avg), 250);

    // Sliding window
    applyStimulus(12'd800, 1'b0);
    checkOutput("slide_handshake_clear", 32'(out_valid), 0);
    idleCycle();
    checkOutput("slide800_avg", 32'(out_avg), 425);
    applyStimulus(12'd0, 1'b0);
    idleCycle();
    checkOutput("slide0_valid", 32'(out_valid), 1);
    checkOutput("slide0_avg", 32'(out_avg), 375);

    // Backpressure and overwrite
    out_ready = 1'b0;
    applyStimulus(12'd500, 1'b0);
    checkOutput("bp_hold_avg", 32'(out_avg), 375);
    applyStimulus(12'd500, 1'b0);
    checkOutput("bp_first_avg", 32'(out_avg), 425);
    checkOutput("bp_first_overrun", 32'(overrun), 1);
    idleCycle();
    checkOutput("bp_second_avg", 32'(out_avg), 450);
    checkOutput("bp_second_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    idleCycle();
    checkOutput("bp_release_valid", 32'(out_valid), 0);
    checkOutput("bp_overrun_sticky", 32'(overrun), 1);

    // Timeout leaves the window untouched
    applyStimulus(12'd4095, 1'b1);
    checkOutput("timeout_miss", 32'(miss_count), 1);
    idleCycle();
    checkOutput("timeout_no_result", 32'(out_valid), 0);
    applyStimulus(12'd600, 1'b0);
    idleCycle();
    checkOutput("after_timeout_avg", 32'(out_avg), 400);

    // Saturating miss counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(12'd4095, 1'b1);
    end
    checkOutput("miss_saturate", 32'(miss_count), 255);
    checkOutput("miss_no_result", 32'(out_valid), 0);

    // Reset while a result is in flight
    applyStimulus(12'd700, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_valid", 32'(out_valid), 0);
    checkOutput("midreset_avg", 32'(out_avg), 0);
    checkOutput("midreset_miss", 32'(miss_count), 0);
    checkOutput("midreset_overrun", 32'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    idleCycle();
    idleCycle();
    checkOutput("postreset_no_result", 32'(out_valid), 0);
    applyStimulus(12'd10, 1'b0);
    applyStimulus(12'd20, 1'b0);
    applyStimulus(12'd30, 1'b0);
    idleCycle();
    checkOutput("reprime_valid", 32'(out_valid), 0);
    applyStimulus(12'd40, 1'b0);
    idleCycle();
    checkOutput("reprime_avg", 32'(out_avg), 25);

    // Outlier behaviour from a window settled at 1000
    pulseReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(12'd1000, 1'b0);
    end
    idleCycle();
    checkOutput("settle_avg", 32'(out_avg), 1000);
`ifdef RANGE_AVERAGER_OUTLIER_REJECT_EN
    for (int i = 0; i < 3; i++) begin
      applyStimulus(12'd3000, 1'b0);
      idleCycle();
      checkOutput("outlier_rejected", 32'(out_valid), 0);
      checkOutput("outlier_miss", 32'(miss_count), i + 1);
    end
    applyStimulus(12'd3000, 1'b0);
    idleCycle();
    checkOutput("outlier_fourth_avg", 32'(out_avg), 1500);
    checkOutput("outlier_fourth_valid", 32'(out_valid), 1);
`else
    for (int i = 0; i < 4; i++) begin
      applyStimulus(12'd3000, 1'b0);
      idleCycle();
      checkOutput("jump_valid", 32'(out_valid), 1);
      checkOutput("jump_avg", 32'(out_avg), 1500 + 500 * i);
    end
    checkOutput("jump_miss", 32'(miss_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
